// File: rtl/fifo_flush_writer.sv
// fifo_flush_writer: serializes 32-bit words into nibble FIFO writes.
// Optional nibble counter: define FIFO_FLUSH_WRITER_STATS_EN.
module fifo_flush_writer #(
  parameter int NIBBLES    = 8,
  parameter int FLUSH_HOLD = 4
) (
  input  logic        wclock,
  input  logic        reset,
  input  logic        word_valid_i,
  input  logic [31:0] word_data_i,
  input  logic        word_flush_i,
  output logic        word_ready_o,
  input  logic        fifo_full_i,
  output logic        fifo_wr_valid_o,
  output logic [3:0]  fifo_wr_data_o,
  output logic        fifo_flush_o,
  output logic        busy_o
`ifdef FIFO_FLUSH_WRITER_STATS_EN
  ,
  output logic [15:0] nibble_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FLUSH
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  idx_q;
  logic [3:0]  hold_q;
  logic [31:0] word_q;
  logic        flush_q;
  logic        armed_q;
  logic        accept;
  logic        last_wr;
  logic        hold_done;

  // armed_q keeps ready low until the first edge after reset release
  assign word_ready_o    = (state_q == IDLE) && armed_q;
  assign accept          = word_valid_i && word_ready_o;
  assign fifo_wr_valid_o = (state_q == SEND) && !fifo_full_i;
  assign last_wr         = fifo_wr_valid_o
                         && (idx_q == 3'(NIBBLES - 1));
  assign hold_done       = hold_q == 4'(FLUSH_HOLD - 1);
  assign fifo_wr_data_o  = (state_q == SEND)
                         ? word_q[{idx_q, 2'b00} +: 4]
                         : 4'h0;
  assign fifo_flush_o    = state_q == FLUSH;
  assign busy_o          = state_q != IDLE;

  // state register
  always_ff @(posedge wclock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SEND;
      SEND:  if (last_wr) state_d = flush_q ? FLUSH : IDLE;
      FLUSH: if (hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // word capture, nibble index and flush hold counter
  always_ff @(posedge wclock or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
      word_q  <= '0;
      flush_q <= 1'b0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        word_q  <= word_data_i;
        flush_q <= word_flush_i;
        idx_q   <= '0;
      end else if (fifo_wr_valid_o) begin
        idx_q <= idx_q + 3'd1;
      end
      hold_q <= (state_q == FLUSH) ? hold_q + 4'd1 : 4'd0;
    end
  end

`ifdef FIFO_FLUSH_WRITER_STATS_EN
  // running count of nibble writes, wraps naturally
  always_ff @(posedge wclock or negedge reset) begin
    if (!reset)               nibble_count_o <= '0;
    else if (fifo_wr_valid_o) nibble_count_o <= nibble_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_flush_writer.sv
// tb_fifo_flush_writer: vector table plus scoreboard for the nibble writer.
// Stats check runs when FIFO_FLUSH_WRITER_STATS_EN is defined.
module tb_fifo_flush_writer;

  logic        wclock;
  logic        reset;
  logic        word_valid_i;
  logic [31:0] word_data_i;
  logic        word_flush_i;
  logic        word_ready_o;
  logic        fifo_full_i;
  logic        fifo_wr_valid_o;
  logic [3:0]  fifo_wr_data_o;
  logic        fifo_flush_o;
  logic        busy_o;
`ifdef FIFO_FLUSH_WRITER_STATS_EN
  logic [15:0] nibble_count_o;
`endif

  fifo_flush_writer #(.NIBBLES(8), .FLUSH_HOLD(4)) dut (
    .wclock          (wclock),
    .reset           (reset),
    .word_valid_i    (word_valid_i),
    .word_data_i     (word_data_i),
    .word_flush_i    (word_flush_i),
    .word_ready_o    (word_ready_o),
    .fifo_full_i     (fifo_full_i),
    .fifo_wr_valid_o (fifo_wr_valid_o),
    .fifo_wr_data_o  (fifo_wr_data_o),
    .fifo_flush_o    (fifo_flush_o),
    .busy_o          (busy_o)
`ifdef FIFO_FLUSH_WRITER_STATS_EN
    ,
    .nibble_count_o  (nibble_count_o)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        flush;
    logic [31:0] seq;
    int          busy;
    int          fl;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         n_wr = 0;
  int         n_fl = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  initial wclock = 1'b0;
  always #5 wclock = ~wclock;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the oldest expected nibble
  always @(negedge wclock) begin
    if (fifo_wr_valid_o) begin
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_write got %0h expected none",
                 fifo_wr_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_wr_data_o !== mon_exp) begin
          errors++;
          $display("FAIL nibble got %0h expected %0h",
                   fifo_wr_data_o, mon_exp);
        end
      end
    end
    if (fifo_flush_o) begin
      n_fl++;
      checks++;
      if (fifo_wr_valid_o) begin
        errors++;
        $display("FAIL overlap got wr=1 flush=1 expected wr=0");
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge wclock);
    while (!word_ready_o && n < 64) begin
      n++;
      @(negedge wclock);
    end
    chk("ready_timeout", {31'd0, word_ready_o}, 32'd1);
  endtask

  task automatic push_seq(input logic [31:0] seq);
    for (int k = 0; k < 8; k++) exp_q.push_back(seq[(7-k)*4 +: 4]);
  endtask

  task automatic send(input logic [31:0] d, input logic f,
                      input logic [31:0] seq);
    int n;
    wait_ready(n);
    word_valid_i = 1'b1;
    word_data_i  = d;
    word_flush_i = f;
    @(posedge wclock);
    push_seq(seq);
    #1;
    word_valid_i = 1'b0;
    word_flush_i = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge wclock);
    while (busy_o && n < 100) begin
      n++;
      @(negedge wclock);
    end
    chk("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  function automatic logic [31:0] rev_nib(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[(7-k)*4 +: 4] = d[k*4 +: 4];
    return r;
  endfunction

  vec_t vecs[6];

  initial begin
    int cyc;
    int w0;
    int f0;
    int n;
    logic [31:0] d;

    vecs[0] = '{32'h87654321, 1'b0, 32'h12345678, 8, 0};
    vecs[1] = '{32'hA5A5A5A5, 1'b1, 32'h5A5A5A5A, 12, 4};
    vecs[2] = '{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 8, 0};
    vecs[3] = '{32'h00000000, 1'b1, 32'h00000000, 12, 4};
    vecs[4] = '{32'h0F1E2D3C, 1'b0, 32'hC3D2E1F0, 8, 0};
    vecs[5] = '{32'hDEADBEEF, 1'b1, 32'hFEEBDAED, 12, 4};

    reset        = 1'b0;
    word_valid_i = 1'b0;
    word_data_i  = '0;
    word_flush_i = 1'b0;
    fifo_full_i  = 1'b0;

    @(negedge wclock);
    chk("rst_ready", {31'd0, word_ready_o}, 32'd0);
    chk("rst_wr", {31'd0, fifo_wr_valid_o}, 32'd0);
    chk("rst_data", {28'd0, fifo_wr_data_o}, 32'd0);
    chk("rst_flush", {31'd0, fifo_flush_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    #2 reset = 1'b1;
    @(negedge wclock);
    chk("ready_after_rst", {31'd0, word_ready_o}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      f0 = n_fl;
      w0 = n_wr;
      send(vecs[i].data, vecs[i].flush, vecs[i].seq);
      wait_idle(cyc);
      chk($sformatf("v%0d_busy", i), cyc, vecs[i].busy);
      chk($sformatf("v%0d_flush", i), n_fl - f0, vecs[i].fl);
      chk($sformatf("v%0d_writes", i), n_wr - w0, 8);
      chk($sformatf("v%0d_drain", i), exp_q.size(), 0);
    end

    send(32'h87654321, 1'b0, 32'h12345678);
    for (int k = 0; k < 8; k++) begin
      @(negedge wclock);
      chk($sformatf("a_strobe%0d", k), {31'd0, fifo_wr_valid_o}, 1);
    end
    @(negedge wclock);
    chk("a_ready_back", {31'd0, word_ready_o}, 32'd1);
    chk("a_wr_low", {31'd0, fifo_wr_valid_o}, 32'd0);

    send(32'hA5A5A5A5, 1'b1, 32'h5A5A5A5A);
    repeat (8) @(negedge wclock);
    for (int k = 0; k < 4; k++) begin
      @(negedge wclock);
      chk($sformatf("b_flush%0d", k), {31'd0, fifo_flush_o}, 1);
      chk($sformatf("b_nowr%0d", k), {31'd0, fifo_wr_valid_o}, 0);
    end
    @(negedge wclock);
    chk("b_flush_end", {31'd0, fifo_flush_o}, 32'd0);
    chk("b_ready", {31'd0, word_ready_o}, 32'd1);

    w0 = n_wr;
    send(32'h87654321, 1'b0, 32'h12345678);
    repeat (2) @(negedge wclock);
    @(posedge wclock);
    #1 fifo_full_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge wclock);
      chk($sformatf("c_stall%0d", k), {31'd0, fifo_wr_valid_o}, 0);
      chk($sformatf("c_hold%0d", k), {28'd0, fifo_wr_data_o}, 3);
    end
    @(posedge wclock);
    #1 fifo_full_i = 1'b0;
    @(negedge wclock);
    chk("c_resume", {31'd0, fifo_wr_valid_o}, 32'd1);
    chk("c_resume_data", {28'd0, fifo_wr_data_o}, 32'd3);
    wait_idle(cyc);
    chk("c_writes", n_wr - w0, 8);
    chk("c_drain", exp_q.size(), 0);

    w0 = n_wr;
    wait_ready(n);
    word_valid_i = 1'b1;
    word_data_i  = 32'h11111111;
    @(posedge wclock);
    push_seq(32'h11111111);
    #1 word_data_i = 32'h22222222;
    wait_ready(n);
    chk("d_wait", n, 8);
    @(posedge wclock);
    push_seq(32'h22222222);
    #1 word_valid_i = 1'b0;
    wait_idle(cyc);
    chk("d_writes", n_wr - w0, 16);
    chk("d_drain", exp_q.size(), 0);

    w0 = n_wr;
    send(32'h87654321, 1'b0, 32'h12345678);
    repeat (4) @(negedge wclock);
    @(posedge wclock);
    #1 reset = 1'b0;
    #1;
    chk("e_wr", {31'd0, fifo_wr_valid_o}, 32'd0);
    chk("e_data", {28'd0, fifo_wr_data_o}, 32'd0);
    chk("e_flush", {31'd0, fifo_flush_o}, 32'd0);
    chk("e_busy", {31'd0, busy_o}, 32'd0);
    chk("e_ready", {31'd0, word_ready_o}, 32'd0);
    exp_q.delete();
    @(negedge wclock);
    #2 reset = 1'b1;
    @(negedge wclock);
    chk("e_ready_back", {31'd0, word_ready_o}, 32'd1);
    repeat (10) @(negedge wclock);
    chk("e_no_residual", n_wr - w0, 4);

`ifdef FIFO_FLUSH_WRITER_STATS_EN
    @(posedge wclock);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge wclock);
    chk("s_rst", {16'd0, nibble_count_o}, 32'd0);
    for (int i = 0; i < 8193; i++) begin
      d = $urandom;
      send(d, 1'b0, rev_nib(d));
    end
    wait_idle(cyc);
    chk("s_wrap", {16'd0, nibble_count_o}, 32'd8);
`endif

    chk("final_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
